// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg
//   Shared constants for the MEM/WB stage: datapath and register-address
//   widths, plus the load-type encodings carried on M_LOAD_TYPE.
package mem_wb_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align
//   Combinational load-data extraction. Selects the byte/half/word lane
//   addressed by the low address bits (little-endian), sign- or zero-extends
//   it, and flags accesses that are not naturally aligned.
//   Ports:
//     load_type  in  3       load encoding (unknown codes behave as LW)
//     addr       in  2       byte offset within the word
//     read_data  in  DATA_W  aligned word from data memory
//     data       out DATA_W  extended load result
//     misalign   out 1       access not naturally aligned
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]        load_type,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] data,
  output logic              misalign
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection for byte and halfword accesses
  always_comb begin
    byte_s = 8'h00;
    case (addr)
      2'd0:    byte_s = read_data[7:0];
      2'd1:    byte_s = read_data[15:8];
      2'd2:    byte_s = read_data[23:16];
      2'd3:    byte_s = read_data[31:24];
      default: byte_s = read_data[7:0];
    endcase
    if (addr[1]) begin
      half_s = read_data[31:16];
    end else begin
      half_s = read_data[15:0];
    end
  end

  // Extension and alignment check per load type
  always_comb begin
    data     = read_data;
    misalign = 1'b0;
    case (load_type)
      LT_LB: begin
        data     = {{24{byte_s[7]}}, byte_s};
        misalign = 1'b0;
      end
      LT_LBU: begin
        data     = {24'h000000, byte_s};
        misalign = 1'b0;
      end
      LT_LH: begin
        data     = {{16{half_s[15]}}, half_s};
        misalign = addr[0];
      end
      LT_LHU: begin
        data     = {16'h0000, half_s};
        misalign = addr[0];
      end
      default: begin
        data     = read_data;
        misalign = (addr != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM/WB pipeline register and writeback for the 5-stage MIPS pipeline.
//   Load data is aligned/extended ahead of the flop so WD3 comes straight
//   from a register. The write enable is also precomputed at capture time,
//   so A3/WD3/WE3 are all register outputs. ID-stage operands are bypassed
//   from the pending writeback because the register file writes on the edge
//   and reads combinationally.
//   Ports:
//     CLK, RESET          clock, async active-low reset
//     STALL, FLUSH        hold / bubble control (FLUSH wins)
//     M_*                 MEM-stage instruction fields
//     A1_ID, A2_ID        ID-stage read addresses
//     RD1_RF, RD2_RF      register-file read data
//     A3, WD3, WE3        register-file write port
//     W_VALID, W_MISALIGN WB status
//     RD1_BYP, RD2_BYP    bypassed operands
//     RETIRED             retired-instruction count (wraps)
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              M_VALID,
  input  logic              M_REG_WRITE,
  input  logic              M_MEM_TO_REG,
  input  logic [2:0]        M_LOAD_TYPE,
  input  logic [REG_AW-1:0] M_WRITE_REG,
  input  logic [DATA_W-1:0] M_ALU_OUT,
  input  logic [DATA_W-1:0] M_READ_DATA,
  input  logic [REG_AW-1:0] A1_ID,
  input  logic [REG_AW-1:0] A2_ID,
  input  logic [DATA_W-1:0] RD1_RF,
  input  logic [DATA_W-1:0] RD2_RF,
  output logic [REG_AW-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  output logic              W_VALID,
  output logic              W_MISALIGN,
  output logic [DATA_W-1:0] RD1_BYP,
  output logic [DATA_W-1:0] RD2_BYP,
  output logic [CNT_W-1:0]  RETIRED
);

  logic [DATA_W-1:0] ld_data_s;
  logic              ld_mis_s;
  logic [DATA_W-1:0] cap_data_s;
  logic              cap_mis_s;
  logic              cap_we_s;
  logic              capture_s;

  logic [REG_AW-1:0] a3_r;
  logic [DATA_W-1:0] wd3_r;
  logic              we3_r;
  logic              w_valid_r;
  logic              w_misalign_r;
  logic [CNT_W-1:0]  retired_r;

  load_align u_load_align (
    .load_type (M_LOAD_TYPE),
    .addr      (M_ALU_OUT[1:0]),
    .read_data (M_READ_DATA),
    .data      (ld_data_s),
    .misalign  (ld_mis_s)
  );

  // Next-state values for the WB register
  always_comb begin
    if (M_MEM_TO_REG) begin
      cap_data_s = ld_data_s;
    end else begin
      cap_data_s = M_ALU_OUT;
    end
    cap_mis_s = M_VALID & M_MEM_TO_REG & ld_mis_s;
    // r0 is hard-wired zero, so a write to it is suppressed here and the
    // bypass can never forward it.
    cap_we_s  = M_VALID & M_REG_WRITE & ~cap_mis_s &
                (M_WRITE_REG != {REG_AW{1'b0}});
    capture_s = ~FLUSH & ~STALL;
  end

  // MEM/WB pipeline register: FLUSH > STALL > capture
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      a3_r         <= {REG_AW{1'b0}};
      wd3_r        <= {DATA_W{1'b0}};
      we3_r        <= 1'b0;
      w_valid_r    <= 1'b0;
      w_misalign_r <= 1'b0;
    end else if (FLUSH) begin
      we3_r        <= 1'b0;
      w_valid_r    <= 1'b0;
      w_misalign_r <= 1'b0;
    end else if (!STALL) begin
      a3_r         <= M_WRITE_REG;
      wd3_r        <= cap_data_s;
      we3_r        <= cap_we_s;
      w_valid_r    <= M_VALID;
      w_misalign_r <= cap_mis_s;
    end
  end

  // Retire counter: counts captured valid, well-aligned instructions
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      retired_r <= {CNT_W{1'b0}};
    end else if (capture_s && M_VALID && !cap_mis_s) begin
      retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Write-to-read bypass for the ID-stage operands
  always_comb begin
    if (we3_r && (A1_ID == a3_r)) begin
      RD1_BYP = wd3_r;
    end else begin
      RD1_BYP = RD1_RF;
    end
    if (we3_r && (A2_ID == a3_r)) begin
      RD2_BYP = wd3_r;
    end else begin
      RD2_BYP = RD2_RF;
    end
  end

  assign A3         = a3_r;
  assign WD3        = wd3_r;
  assign WE3        = we3_r;
  assign W_VALID    = w_valid_r;
  assign W_MISALIGN = w_misalign_r;
  assign RETIRED    = retired_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
//   Directed self-checking bench for mem_wb_stage. Inputs change 1ns after
//   a rising edge; outputs are sampled at that same point, away from the edge.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        STALL = 1'b0;
  logic        FLUSH = 1'b0;
  logic        M_VALID = 1'b0;
  logic        M_REG_WRITE = 1'b0;
  logic        M_MEM_TO_REG = 1'b0;
  logic [2:0]  M_LOAD_TYPE = 3'b000;
  logic [4:0]  M_WRITE_REG = 5'd0;
  logic [31:0] M_ALU_OUT = 32'h0;
  logic [31:0] M_READ_DATA = 32'h0;
  logic [4:0]  A1_ID = 5'd0;
  logic [4:0]  A2_ID = 5'd0;
  logic [31:0] RD1_RF = 32'h0;
  logic [31:0] RD2_RF = 32'h0;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic        W_VALID;
  logic        W_MISALIGN;
  logic [31:0] RD1_BYP;
  logic [31:0] RD2_BYP;
  logic [31:0] RETIRED;

  int n_asrt = 0;
  int n_fail = 0;

  mem_wb_stage #(.CNT_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .M_VALID(M_VALID), .M_REG_WRITE(M_REG_WRITE), .M_MEM_TO_REG(M_MEM_TO_REG),
    .M_LOAD_TYPE(M_LOAD_TYPE), .M_WRITE_REG(M_WRITE_REG), .M_ALU_OUT(M_ALU_OUT),
    .M_READ_DATA(M_READ_DATA), .A1_ID(A1_ID), .A2_ID(A2_ID),
    .RD1_RF(RD1_RF), .RD2_RF(RD2_RF), .A3(A3), .WD3(WD3), .WE3(WE3),
    .W_VALID(W_VALID), .W_MISALIGN(W_MISALIGN), .RD1_BYP(RD1_BYP),
    .RD2_BYP(RD2_BYP), .RETIRED(RETIRED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [2:0] lt, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] rd);
    M_VALID = v; M_REG_WRITE = rw; M_MEM_TO_REG = m2r; M_LOAD_TYPE = lt;
    M_WRITE_REG = wr; M_ALU_OUT = alu; M_READ_DATA = rd;
  endtask

  initial begin
    // Reset state
    RD1_RF = 32'h0000_1111; RD2_RF = 32'h0000_2222; A1_ID = 5'd0; A2_ID = 5'd0;
    #12;
    chk("rst_a3", {27'd0, A3}, 32'd0);
    chk("rst_wd3", WD3, 32'd0);
    chk("rst_we3", {31'd0, WE3}, 32'd0);
    chk("rst_wvalid", {31'd0, W_VALID}, 32'd0);
    chk("rst_mis", {31'd0, W_MISALIGN}, 32'd0);
    chk("rst_ret", RETIRED, 32'd0);
    chk("rst_rd1", RD1_BYP, 32'h0000_1111);
    chk("rst_rd2", RD2_BYP, 32'h0000_2222);
    RESET = 1'b1;
    step();

    // ALU write r8
    drive(1'b1, 1'b1, 1'b0, LT_LW, 5'd8, 32'h1234_5678, 32'h0);
    step();
    chk("alu_a3", {27'd0, A3}, 32'd8);
    chk("alu_wd3", WD3, 32'h1234_5678);
    chk("alu_we3", {31'd0, WE3}, 32'd1);
    chk("alu_ret", RETIRED, 32'd1);

    // Byte loads
    drive(1'b1, 1'b1, 1'b1, LT_LB, 5'd5, 32'h0000_1003, 32'h80FF_7F01);
    step();
    chk("lb3_wd3", WD3, 32'hFFFF_FF80);
    chk("lb3_ret", RETIRED, 32'd2);
    drive(1'b1, 1'b1, 1'b1, LT_LBU, 5'd5, 32'h0000_1003, 32'h80FF_7F01);
    step();
    chk("lbu3_wd3", WD3, 32'h0000_0080);
    drive(1'b1, 1'b1, 1'b1, LT_LB, 5'd5, 32'h0000_1001, 32'h80FF_7F01);
    step();
    chk("lb1_wd3", WD3, 32'h0000_007F);
    chk("lb1_ret", RETIRED, 32'd4);

    // Halfword loads
    drive(1'b1, 1'b1, 1'b1, LT_LH, 5'd6, 32'h0000_1001, 32'h80FF_7F01);
    step();
    chk("lhmis_mis", {31'd0, W_MISALIGN}, 32'd1);
    chk("lhmis_we3", {31'd0, WE3}, 32'd0);
    chk("lhmis_ret", RETIRED, 32'd4);
    drive(1'b1, 1'b1, 1'b1, LT_LHU, 5'd6, 32'h0000_1002, 32'h80FF_7F01);
    step();
    chk("lhu2_wd3", WD3, 32'h0000_80FF);
    chk("lhu2_we3", {31'd0, WE3}, 32'd1);
    chk("lhu2_mis", {31'd0, W_MISALIGN}, 32'd0);
    chk("lhu2_ret", RETIRED, 32'd5);
    drive(1'b1, 1'b1, 1'b1, LT_LH, 5'd6, 32'h0000_1002, 32'h80FF_7F01);
    step();
    chk("lh2_wd3", WD3, 32'hFFFF_80FF);

    // Word loads
    drive(1'b1, 1'b1, 1'b1, LT_LW, 5'd7, 32'h0000_1002, 32'h80FF_7F01);
    step();
    chk("lwmis_mis", {31'd0, W_MISALIGN}, 32'd1);
    chk("lwmis_we3", {31'd0, WE3}, 32'd0);
    chk("lwmis_ret", RETIRED, 32'd6);
    drive(1'b1, 1'b1, 1'b1, LT_LW, 5'd7, 32'h0000_1000, 32'h80FF_7F01);
    step();
    chk("lw0_wd3", WD3, 32'h80FF_7F01);
    chk("lw0_ret", RETIRED, 32'd7);

    // Bypass from WB write of r9
    drive(1'b1, 1'b1, 1'b0, LT_LW, 5'd9, 32'hDEAD_BEEF, 32'h0);
    A1_ID = 5'd9; A2_ID = 5'd10; RD1_RF = 32'h0; RD2_RF = 32'h2222_2222;
    step();
    chk("byp_rd1", RD1_BYP, 32'hDEAD_BEEF);
    chk("byp_rd2", RD2_BYP, 32'h2222_2222);
    A2_ID = 5'd9; RD2_RF = 32'h4444_4444;
    #1;
    chk("byp_rd2_hit", RD2_BYP, 32'hDEAD_BEEF);

    // Write to r0 never writes or bypasses
    drive(1'b1, 1'b1, 1'b0, LT_LW, 5'd0, 32'h0000_0055, 32'h0);
    A1_ID = 5'd0; RD1_RF = 32'h0000_3333;
    step();
    chk("r0_we3", {31'd0, WE3}, 32'd0);
    chk("r0_wvalid", {31'd0, W_VALID}, 32'd1);
    chk("r0_rd1", RD1_BYP, 32'h0000_3333);
    chk("r0_ret", RETIRED, 32'd9);

    // FLUSH with STALL: flush wins
    drive(1'b1, 1'b1, 1'b0, LT_LW, 5'd12, 32'h0000_ABCD, 32'h0);
    step();
    chk("pre_fl_we3", {31'd0, WE3}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, LT_LW, 5'd11, 32'h0000_0111, 32'h0);
    FLUSH = 1'b1; STALL = 1'b1;
    step();
    FLUSH = 1'b0; STALL = 1'b0;
    chk("fl_wvalid", {31'd0, W_VALID}, 32'd0);
    chk("fl_we3", {31'd0, WE3}, 32'd0);
    chk("fl_ret", RETIRED, 32'd10);

    // STALL alone for three cycles holds WB
    drive(1'b1, 1'b1, 1'b0, LT_LW, 5'd13, 32'h0000_0777, 32'h0);
    step();
    chk("pre_st_ret", RETIRED, 32'd11);
    drive(1'b1, 1'b1, 1'b0, LT_LW, 5'd14, 32'h0000_0999, 32'h0);
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_a3", {27'd0, A3}, 32'd13);
      chk("st_wd3", WD3, 32'h0000_0777);
      chk("st_we3", {31'd0, WE3}, 32'd1);
      chk("st_ret", RETIRED, 32'd11);
    end
    STALL = 1'b0;

    // Bubble: invalid instruction does not write or retire
    drive(1'b0, 1'b1, 1'b0, LT_LW, 5'd14, 32'h0000_0999, 32'h0);
    step();
    chk("bub_wvalid", {31'd0, W_VALID}, 32'd0);
    chk("bub_we3", {31'd0, WE3}, 32'd0);
    chk("bub_ret", RETIRED, 32'd11);

    // Async reset mid-cycle discards the in-flight write
    drive(1'b1, 1'b1, 1'b0, LT_LW, 5'd15, 32'h0000_0F0F, 32'h0);
    step();
    chk("pre_ar_we3", {31'd0, WE3}, 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    chk("ar_we3", {31'd0, WE3}, 32'd0);
    chk("ar_wvalid", {31'd0, W_VALID}, 32'd0);
    chk("ar_ret", RETIRED, 32'd0);
    chk("ar_wd3", WD3, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
